// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: FSM encoding and parameter defaults.
package seq_det_pkg;

  localparam int unsigned MAXLEN_DEF = 8;
  localparam int unsigned CNTW_DEF   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/pattern_match.sv
// History shift register, saturating bits-seen counter and masked pattern compare.
// hit is valid only in the cycle right after a shift, so each received bit yields at most one hit.
import seq_det_pkg::*;

module pattern_match #(
  parameter int unsigned MAXLEN = MAXLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [3:0]        len,
  output logic              hit
);

  localparam int unsigned SeenW = $clog2(MAXLEN + 1);

  logic [MAXLEN-1:0] history_q;
  logic [SeenW-1:0]  seen_q;
  logic              fresh_q;
  logic              eq;

  // Shift new bits into the LSB; count bits seen up to MAXLEN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history_q <= '0;
      seen_q    <= '0;
      fresh_q   <= 1'b0;
    end else if (clr) begin
      history_q <= '0;
      seen_q    <= '0;
      fresh_q   <= 1'b0;
    end else begin
      fresh_q <= shift;
      if (shift) begin
        history_q <= {history_q[MAXLEN-2:0], bit_in};
        if (seen_q != SeenW'(MAXLEN)) begin
          seen_q <= seen_q + SeenW'(1);
        end
      end
    end
  end

  // Compare only the low len bits; pattern[len-1] lines up with the oldest bit.
  always_comb begin
    eq = 1'b1;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      if (i < int'(len) && history_q[i] != pattern[i]) begin
        eq = 1'b0;
      end
    end
  end

  assign hit = fresh_q & eq & (32'(seen_q) >= 32'(len));

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: config latch, FSM, match counter.
// A hit seen in RUN is registered into a one-cycle match pulse; reaching the target
// moves to DONE on the same edge, so done rises together with the final match.
import seq_det_pkg::*;

module seq_detect_ctrl #(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned CNTW   = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              stop,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              match,
  output logic [CNTW-1:0]   match_cnt,
  output logic              done,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic [MAXLEN-1:0] pattern_q;
  logic [3:0]        len_q;
  logic [CNTW-1:0]   target_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              err_q, err_d;
  logic              len_ok;
  logic              hit;
  logic              idle_like;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign len_ok    = (len_q != 4'd0) && (int'(len_q) <= int'(MAXLEN));

  pattern_match #(
    .MAXLEN (MAXLEN)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_LOAD),
    .shift   ((state_q == ST_RUN) && bit_valid),
    .bit_in  (bit_in),
    .pattern (pattern_q),
    .len     (len_q),
    .hit     (hit)
  );

  // Next-state, counter and pulse logic; stop outranks everything while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len_ok) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          match_d = 1'b1;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
          if (target_q != '0 && cnt_d == target_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // Config is writable only while no run is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      target_q  <= '0;
    end else if (cfg_we && idle_like) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      target_q  <= cfg_target;
    end
  end

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start;
  logic       stop;
  logic       bit_valid;
  logic       bit_in;
  logic       busy;
  logic       match;
  logic [7:0] match_cnt;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_ctrl #(
    .MAXLEN (8),
    .CNTW   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    tick();
    cfg_we = 1'b0;
  endtask

  // IDLE/DONE -> LOAD -> RUN
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; bit_in = b;
    tick();
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  // mv[k] set when a match pulse is attributed to the k-th (1-based) bit of the stream.
  task automatic run_stream(input logic [31:0] bits, input int n, output logic [31:0] mv);
    mv = '0;
    for (int k = 0; k < n; k++) begin
      send_bit(bits[n-1-k]);
      if (match) mv[k] = 1'b1;
    end
    tick();
    if (match) mv[n] = 1'b1;
  endtask

  initial begin
    logic [31:0] mv;
    int nm;
    int done_at;
    logic seen_done;

    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tick(); tick();
    check_eq("rst_outs", {27'd0, busy, match, done, err}, 32'd0);
    check_eq("rst_cnt", {24'd0, match_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Start before any config: len resets to 0.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("nocfg_err", {31'd0, err}, 32'd1);
    check_eq("nocfg_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("nocfg_err_pulse", {31'd0, err}, 32'd0);

    // Basic run with target 2.
    cfg(8'b0110, 4'd4, 8'd2);
    do_start();
    check_eq("t28_busy_run", {31'd0, busy}, 32'd1);
    run_stream(32'b10110110, 8, mv);
    check_eq("t28_match_pos", mv, 32'h120);
    check_eq("t28_cnt", {24'd0, match_cnt}, 32'd2);
    check_eq("t28_done", {31'd0, done}, 32'd1);
    check_eq("t28_busy", {31'd0, busy}, 32'd0);

    // Unlimited target, overlapping matches; restart from DONE.
    cfg(8'b0110, 4'd4, 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("t29_load_cnt", {24'd0, match_cnt}, 32'd0);
    check_eq("t29_load_done", {31'd0, done}, 32'd0);
    tick();
    run_stream(32'b0110110110, 10, mv);
    check_eq("t29_match_pos", mv, 32'h490);
    check_eq("t29_cnt", {24'd0, match_cnt}, 32'd3);
    check_eq("t29_state", {30'd0, busy, done}, 32'b10);

    // start+stop while busy: stop wins, count retained.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("ss_busy_stop", {31'd0, busy}, 32'd0);
    check_eq("ss_cnt_hold", {24'd0, match_cnt}, 32'd3);
    // start+stop while idle: start wins; then stop in LOAD.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("ss_idle_start", {31'd0, busy}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_in_load", {31'd0, busy}, 32'd0);

    // Bad lengths.
    cfg(8'b0110, 4'd0, 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("len0_err", {30'd0, err, busy}, 32'b10);
    cfg(8'b0110, 4'd9, 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("len9_err", {30'd0, err, busy}, 32'b10);

    // Config write during RUN is ignored.
    cfg(8'b0110, 4'd4, 8'd0);
    do_start();
    cfg(8'b1111, 4'd4, 8'd0);
    run_stream(32'b0110, 4, mv);
    check_eq("cfg_locked_pos", mv, 32'h10);
    check_eq("cfg_locked_cnt", {24'd0, match_cnt}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Stop right after the completing bit suppresses the pending match.
    do_start();
    run_stream(32'b0110, 4, mv);
    check_eq("stop_pre_cnt", {24'd0, match_cnt}, 32'd1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_no_match", {31'd0, match}, 32'd0);
    check_eq("stop_idle", {30'd0, busy, done}, 32'd0);
    check_eq("stop_cnt_hold", {24'd0, match_cnt}, 32'd1);
    tick();
    check_eq("stop_no_late_match", {31'd0, match}, 32'd0);

    // Asynchronous reset mid-run.
    do_start();
    run_stream(32'b0110, 4, mv);
    check_eq("rst_mid_pre", {24'd0, match_cnt}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_outs", {19'd0, busy, match, done, err, match_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    cfg(8'b0110, 4'd4, 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("rerun_load_cnt", {24'd0, match_cnt}, 32'd0);
    tick();
    run_stream(32'b0110, 4, mv);
    check_eq("rerun_pos", mv, 32'h10);
    check_eq("rerun_cnt", {24'd0, match_cnt}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Saturation at target 255 with a one-bit pattern.
    cfg(8'b1, 4'd1, 8'd255);
    do_start();
    nm = 0; done_at = -1; seen_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send_bit(1'b1);
      if (match) nm++;
      if (done && !seen_done) begin
        seen_done = 1'b1;
        done_at = nm;
      end
    end
    tick();
    if (match) nm++;
    check_eq("sat_pulses", nm, 32'd255);
    check_eq("sat_cnt", {24'd0, match_cnt}, 32'd255);
    check_eq("sat_done_at", done_at, 32'd255);
    check_eq("sat_state", {30'd0, busy, done}, 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
